decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage.sv | 165 ++++++++++++++++
 tb/tb_decode_stage.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// Instruction decode stage: decodes one instruction per accept, reads GPR operands,
// and presents the bundle through a one-deep output register backed by one skid entry.
module decode_stage #(
  parameter int  XLEN  = 64,
  parameter int  NREGS = 32,
  localparam int RW    = $clog2(NREGS)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [31:0]           i_insn,
  input  logic [XLEN*NREGS-1:0] i_gpr,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [3:0]            o_to_state,
  output logic [3:0]            o_alu_op,
  output logic [1:0]            o_sz,
  output logic [XLEN-1:0]       o_src1,
  output logic [XLEN-1:0]       o_src2,
  output logic [RW-1:0]         o_dst,
  output logic                  o_illegal,
  output logic                  o_halted,
  input  logic                  i_resume
);

  typedef enum logic [3:0] {
    STATE_EXECUTE     = 4'd2,
    STATE_SRC1_TO_DST = 4'd3,
    STATE_HALT        = 4'd4
  } cpu_state_e;

  typedef struct packed {
    logic [3:0]      to_state;
    logic [3:0]      alu_op;
    logic [1:0]      sz;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic [RW-1:0]   dst;
    logic            illegal;
  } bundle_t;

  logic [1:0]  k;
  logic [3:0]  k1;
  logic [15:0] imm;
  logic [4:0]  s1, s2, d;
  logic        unused_insn_msb;

  assign k               = i_insn[30:29];
  assign k1              = i_insn[19:16];
  assign imm             = i_insn[15:0];
  assign s1              = i_insn[19:15];
  assign s2              = i_insn[14:10];
  assign d               = i_insn[24:20];
  assign unused_insn_msb = i_insn[31];

  // Fixed 32-entry view; indices beyond NREGS read as zero so wide fields never index out of range.
  logic [XLEN-1:0] gpr [32];
  for (genvar g = 0; g < 32; g++) begin : g_gpr
    if (g < NREGS) begin : g_real
      assign gpr[g] = i_gpr[g*XLEN +: XLEN];
    end else begin : g_none
      assign gpr[g] = '0;
    end
  end

  function automatic logic reg_bad(input logic [4:0] r);
    return {1'b0, r} >= 6'(NREGS);
  endfunction

  bundle_t         dec;
  logic            ill;
  logic [XLEN-1:0] hi;

  always_comb begin
    dec          = '0;
    ill          = 1'b0;
    hi           = XLEN'(imm) << {k1[1:0], 4'b0000};
    dec.sz       = i_insn[28:27];
    dec.dst      = d[RW-1:0];
    dec.to_state = STATE_EXECUTE;
    dec.src1     = gpr[s1];
    dec.src2     = gpr[s2];
    unique case (k)
      2'b00: begin
        if (i_insn[28:0] == '0) dec.to_state = STATE_HALT;
        else                    ill          = 1'b1;
      end
      2'b01: begin
        dec.to_state = STATE_SRC1_TO_DST;
        if (reg_bad(d)) ill = 1'b1;
        if (k1 == 4'd0)                          dec.src1 = XLEN'(imm);
        else if (k1 == 4'd1)                     dec.src1 = gpr[d] | hi;
        else if (k1 <= 4'd3 && XLEN == 64)       dec.src1 = gpr[d] | hi;
        else                                     ill      = 1'b1;
      end
      2'b11: begin
        dec.alu_op = i_insn[3:0];
        if (reg_bad(s1) || reg_bad(s2) || reg_bad(d)) ill = 1'b1;
      end
      default: ill = 1'b1;
    endcase
    if (ill) begin
      dec.to_state = STATE_EXECUTE;
      dec.alu_op   = '0;
      dec.src1     = '0;
      dec.src2     = '0;
      dec.illegal  = 1'b1;
    end
  end

  bundle_t out_q, skid_q;
  logic    out_v, skid_v, halted, ready_q;
  logic    accept, drain, skid_nx, halted_nx;

  assign accept    = i_valid && ready_q;
  assign drain     = out_v && i_ready;
  assign skid_nx   = skid_v ? !drain : (accept && out_v && !drain);
  assign halted_nx = (accept && dec.to_state == STATE_HALT) ? 1'b1 :
                     (i_resume ? 1'b0 : halted);

  // Ready looks at the next skid state so a filling skid blocks intake at once,
  // but at the current halted flag so a resume takes one extra cycle to reopen.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      out_q   <= '0;
      skid_q  <= '0;
      out_v   <= 1'b0;
      skid_v  <= 1'b0;
      halted  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      if (skid_v) begin
        if (drain) begin
          out_q  <= skid_q;
          skid_v <= 1'b0;
        end
      end else if (accept) begin
        if (!out_v || i_ready) begin
          out_q <= dec;
          out_v <= 1'b1;
        end else begin
          skid_q <= dec;
          skid_v <= 1'b1;
        end
      end else if (drain) begin
        out_v <= 1'b0;
      end
      halted  <= halted_nx;
      ready_q <= !skid_nx && !halted_nx && !halted;
    end
  end

  assign o_ready    = ready_q;
  assign o_valid    = out_v;
  assign o_halted   = halted;
  assign o_to_state = out_q.to_state;
  assign o_alu_op   = out_q.alu_op;
  assign o_sz       = out_q.sz;
  assign o_src1     = out_q.src1;
  assign o_src2     = out_q.src2;
  assign o_dst      = out_q.dst;
  assign o_illegal  = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: two configurations (64x32 and 32x16) share one stimulus stream
// and are checked against a queue-based reference model, plus directed literal checks.
module tb_decode_stage;

  localparam logic [3:0] ST_EXEC = 4'd2;
  localparam logic [3:0] ST_S2D  = 4'd3;
  localparam logic [3:0] ST_HALT = 4'd4;

  typedef struct packed {
    logic [3:0]  to_state;
    logic [3:0]  alu;
    logic [1:0]  sz;
    logic [63:0] src1;
    logic [63:0] src2;
    logic [4:0]  dst;
    logic        ill;
  } bundle_t;

  typedef struct packed {
    logic [31:0]   insn;
    logic [2047:0] gpr;
  } entry_t;

  logic          clk = 1'b0;
  logic          rst, valid, cons_ready, resume;
  logic [31:0]   insn;
  logic [2047:0] gpr_flat;
  logic [511:0]  gpr32;

  logic        a_ready, a_valid, a_ill, a_halted;
  logic [3:0]  a_state, a_alu;
  logic [1:0]  a_sz;
  logic [63:0] a_src1, a_src2;
  logic [4:0]  a_dst;

  logic        b_ready, b_valid, b_ill, b_halted;
  logic [3:0]  b_state, b_alu;
  logic [1:0]  b_sz;
  logic [31:0] b_src1, b_src2;
  logic [3:0]  b_dst;

  int n_cmp = 0;
  int n_bad = 0;

  entry_t q[$];
  logic   m_halted = 1'b0;
  logic   m_ready  = 1'b0;

  always #5 clk = ~clk;

  always_comb begin
    gpr32 = '0;
    for (int i = 0; i < 16; i++) gpr32[i*32 +: 32] = gpr_flat[i*64 +: 32];
  end

  decode_stage #(.XLEN(64), .NREGS(32)) dut64 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(a_ready), .i_insn(insn),
    .i_gpr(gpr_flat), .o_valid(a_valid), .i_ready(cons_ready), .o_to_state(a_state),
    .o_alu_op(a_alu), .o_sz(a_sz), .o_src1(a_src1), .o_src2(a_src2), .o_dst(a_dst),
    .o_illegal(a_ill), .o_halted(a_halted), .i_resume(resume)
  );

  decode_stage #(.XLEN(32), .NREGS(16)) dut32 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(b_ready), .i_insn(insn),
    .i_gpr(gpr32), .o_valid(b_valid), .i_ready(cons_ready), .o_to_state(b_state),
    .o_alu_op(b_alu), .o_sz(b_sz), .o_src1(b_src1), .o_src2(b_src2), .o_dst(b_dst),
    .o_illegal(b_ill), .o_halted(b_halted), .i_resume(resume)
  );

  bundle_t act64, act32;
  always_comb begin
    act64 = '0;
    act64.to_state = a_state; act64.alu = a_alu; act64.sz = a_sz;
    act64.src1 = a_src1; act64.src2 = a_src2; act64.dst = a_dst; act64.ill = a_ill;
    act32 = '0;
    act32.to_state = b_state; act32.alu = b_alu; act32.sz = b_sz;
    act32.src1 = 64'(b_src1); act32.src2 = 64'(b_src2); act32.dst = 5'(b_dst); act32.ill = b_ill;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_bundle(input string tag, input bundle_t act, input bundle_t exp);
    chk({tag, ".to_state"}, 64'(act.to_state), 64'(exp.to_state));
    chk({tag, ".alu_op"},   64'(act.alu),      64'(exp.alu));
    chk({tag, ".sz"},       64'(act.sz),       64'(exp.sz));
    chk({tag, ".src1"},     act.src1,          exp.src1);
    chk({tag, ".src2"},     act.src2,          exp.src2);
    chk({tag, ".dst"},      64'(act.dst),      64'(exp.dst));
    chk({tag, ".illegal"},  64'(act.ill),      64'(exp.ill));
  endtask

  function automatic logic [63:0] greg(input entry_t e, input int r, input int nregs);
    return (r < nregs) ? e.gpr[r*64 +: 64] : 64'd0;
  endfunction

  // What the bundle must be, straight from the instruction-format rules.
  function automatic bundle_t model_dec(input entry_t e, input int xlen, input int nregs);
    bundle_t     b;
    logic [31:0] w;
    logic [15:0] imm;
    logic [63:0] mask;
    int          kk, kk1, s1, s2, d;
    logic        ill;
    w    = e.insn;
    kk   = int'(w[30:29]);
    kk1  = int'(w[19:16]);
    imm  = w[15:0];
    s1   = int'(w[19:15]);
    s2   = int'(w[14:10]);
    d    = int'(w[24:20]);
    mask = (xlen == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    b          = '0;
    b.sz       = w[28:27];
    b.dst      = 5'(d % nregs);
    b.to_state = ST_EXEC;
    b.src1     = greg(e, s1, nregs);
    b.src2     = greg(e, s2, nregs);
    ill        = 1'b0;
    if (kk == 0) begin
      if (w[28:0] == 29'd0) b.to_state = ST_HALT;
      else                  ill = 1'b1;
    end else if (kk == 1) begin
      b.to_state = ST_S2D;
      if (d >= nregs) ill = 1'b1;
      if (kk1 == 0) b.src1 = 64'(imm);
      else if (kk1 <= 3) begin
        if (xlen == 32 && kk1 >= 2) ill = 1'b1;
        else b.src1 = greg(e, d, nregs) | (64'(imm) << (16 * kk1));
      end else ill = 1'b1;
    end else if (kk == 3) begin
      b.alu = w[3:0];
      if (s1 >= nregs || s2 >= nregs || d >= nregs) ill = 1'b1;
    end else begin
      ill = 1'b1;
    end
    if (ill) begin
      b.to_state = ST_EXEC;
      b.alu      = 4'd0;
      b.src1     = 64'd0;
      b.src2     = 64'd0;
    end
    b.ill  = ill;
    b.src1 = b.src1 & mask;
    b.src2 = b.src2 & mask;
    return b;
  endfunction

  // Flow model: a FIFO of at most two bundles, intake closed when full or halted.
  initial begin
    logic acc, drn, was_halted;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        q.delete();
        m_halted = 1'b0;
        m_ready  = 1'b0;
      end else begin
        acc        = valid && m_ready;
        drn        = (q.size() > 0) && cons_ready;
        was_halted = m_halted;
        if (drn) void'(q.pop_front());
        if (acc) q.push_back('{insn: insn, gpr: gpr_flat});
        if (acc && model_dec('{insn: insn, gpr: gpr_flat}, 64, 32).to_state == ST_HALT)
          m_halted = 1'b1;
        else if (resume && m_halted)
          m_halted = 1'b0;
        m_ready = (q.size() < 2) && !m_halted && !was_halted;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("rst.valid64", 64'(a_valid), 64'd0);
      chk("rst.ready64", 64'(a_ready), 64'd0);
      chk("rst.valid32", 64'(b_valid), 64'd0);
      chk("rst.ready32", 64'(b_ready), 64'd0);
      cmp_bundle("rst.b64", act64, '0);
      cmp_bundle("rst.b32", act32, '0);
    end else begin
      chk("valid64",  64'(a_valid),  64'(q.size() > 0));
      chk("valid32",  64'(b_valid),  64'(q.size() > 0));
      chk("ready64",  64'(a_ready),  64'(m_ready));
      chk("ready32",  64'(b_ready),  64'(m_ready));
      chk("halted64", 64'(a_halted), 64'(m_halted));
      chk("halted32", 64'(b_halted), 64'(m_halted));
      if (q.size() > 0) begin
        cmp_bundle("out64", act64, model_dec(q[0], 64, 32));
        cmp_bundle("out32", act32, model_dec(q[0], 32, 16));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_gpr;
    for (int i = 0; i < 32; i++) gpr_flat[i*64 +: 64] = {$urandom, $urandom};
  endtask

  function automatic logic [31:0] rand_insn();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 9))
      0:       r = {r[31], 31'd0};
      1:       r[30:29] = 2'b00;
      2:       r[30:29] = 2'b10;
      3, 4, 5: begin r[30:29] = 2'b01; r[19:16] = 4'($urandom_range(0, 5)); end
      default: r[30:29] = 2'b11;
    endcase
    return r;
  endfunction

  initial begin
    rst = 1'b1; valid = 1'b0; cons_ready = 1'b0; resume = 1'b0; insn = '0;
    rand_gpr();
    tick(); tick();
    chk("lit.rst_valid", 64'(a_valid), 64'd0);
    chk("lit.rst_ready", 64'(a_ready), 64'd0);
    rst = 1'b0;
    tick();
    chk("lit.ready_after_rst", 64'(a_ready), 64'd1);

    // Load-immediate OR into gpr[3]
    cons_ready = 1'b1;
    gpr_flat[3*64 +: 64] = 64'h0000_0000_0000_00FF;
    insn = 32'h2031_1234; valid = 1'b1;
    tick();
    chk("lit.ldi_valid", 64'(a_valid), 64'd1);
    chk("lit.ldi_src1_64", a_src1, 64'h0000_0000_1234_00FF);
    chk("lit.ldi_state", 64'(a_state), 64'(ST_S2D));
    chk("lit.ldi_dst", 64'(a_dst), 64'd3);
    chk("lit.ldi_src1_32", 64'(b_src1), 64'h1234_00FF);

    // ALU op with s1=20: illegal only when NREGS=16
    insn = 32'h600A_0000;
    tick();
    chk("lit.s1oob_ill32", 64'(b_ill), 64'd1);
    chk("lit.s1oob_valid32", 64'(b_valid), 64'd1);
    chk("lit.s1oob_src1_32", 64'(b_src1), 64'd0);
    chk("lit.s1oob_ill64", 64'(a_ill), 64'd0);

    // k1=0011 shift by 48: illegal only when XLEN=32
    insn = 32'h2003_0000;
    tick();
    valid = 1'b0;
    chk("lit.sh48_ill32", 64'(b_ill), 64'd1);
    chk("lit.sh48_ill64", 64'(a_ill), 64'd0);
    tick();

    // Backpressure: two accepted, third stalls until drained, order kept
    cons_ready = 1'b0;
    insn = 32'h6000_0001; valid = 1'b1;
    tick();
    insn = 32'h6000_0002;
    tick();
    insn = 32'h6000_0003;
    chk("lit.bp_ready_full", 64'(a_ready), 64'd0);
    tick();
    chk("lit.bp_ready_held", 64'(a_ready), 64'd0);
    chk("lit.bp_first", 64'(a_alu), 64'd1);
    cons_ready = 1'b1;
    tick();
    chk("lit.bp_second", 64'(a_alu), 64'd2);
    chk("lit.bp_ready_reopen", 64'(a_ready), 64'd1);
    tick();
    valid = 1'b0;
    chk("lit.bp_third", 64'(a_alu), 64'd3);
    tick();
    chk("lit.bp_empty", 64'(a_valid), 64'd0);

    // Halt then resume
    insn = 32'h0000_0000; valid = 1'b1;
    tick();
    valid = 1'b0;
    chk("lit.halt_halted", 64'(a_halted), 64'd1);
    chk("lit.halt_ready", 64'(a_ready), 64'd0);
    chk("lit.halt_state", 64'(a_state), 64'(ST_HALT));
    tick();
    resume = 1'b1;
    tick();
    resume = 1'b0;
    chk("lit.resume_halted", 64'(a_halted), 64'd0);
    chk("lit.resume_ready_1", 64'(a_ready), 64'd0);
    tick();
    chk("lit.resume_ready_2", 64'(a_ready), 64'd1);

    // Reset with output and skid both occupied
    cons_ready = 1'b0;
    insn = 32'h6000_0005; valid = 1'b1;
    tick();
    insn = 32'h6000_0006;
    tick();
    valid = 1'b0;
    chk("lit.full_valid", 64'(a_valid), 64'd1);
    #1 rst = 1'b1;
    #1;
    chk("lit.async_rst_valid", 64'(a_valid), 64'd0);
    chk("lit.async_rst_ready", 64'(a_ready), 64'd0);
    tick();
    rst = 1'b0; cons_ready = 1'b1;
    tick();
    chk("lit.post_rst_ready", 64'(a_ready), 64'd1);
    chk("lit.post_rst_valid", 64'(a_valid), 64'd0);
    tick();
    chk("lit.no_stale", 64'(a_valid), 64'd0);

    for (int n = 0; n < 3000; n++) begin
      rand_gpr();
      insn       = rand_insn();
      valid      = ($urandom_range(0, 3) != 0);
      cons_ready = ($urandom_range(0, 2) != 0);
      resume     = ($urandom_range(0, 5) == 0);
      rst        = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0; valid = 1'b0; resume = 1'b0;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
